// File: rtl/plic_gateway_sync.sv
// Per-source PLIC interrupt gateway: synchronises level interrupts, issues one request per
// level and blocks further requests until the handler signals completion.
module plic_gateway_sync #(
    parameter int NSRC        = 4,
    parameter int SYNC_STAGES = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NSRC-1:0] io_src,
    output logic [NSRC-1:0] io_valid,
    input  logic [NSRC-1:0] io_ready,
    input  logic [NSRC-1:0] io_complete,
    output logic [NSRC-1:0] io_inflight,
    output logic            io_any_valid
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_INFLIGHT = 2'd2
    } gw_state_e;

    logic [NSRC-1:0] sync_q [SYNC_STAGES];
    logic [NSRC-1:0] sync_level;

    gw_state_e       state_q [NSRC];
    gw_state_e       state_d [NSRC];

    logic [NSRC-1:0] valid_q;
    logic [NSRC-1:0] valid_d;
    logic [NSRC-1:0] inflight_q;
    logic [NSRC-1:0] inflight_d;
    logic            any_valid_q;
    logic            any_valid_d;

    // Plain flop chain; the first stage may go metastable, later stages give it time to settle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= io_src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            // NOTE: every comb output gets a default first so no path can infer a latch.
            state_d[i] = state_q[i];
            unique case (state_q[i])
                ST_IDLE:     if (sync_level[i])  state_d[i] = ST_REQ;
                ST_REQ:      if (io_ready[i])    state_d[i] = ST_INFLIGHT;
                ST_INFLIGHT: if (io_complete[i]) state_d[i] = ST_IDLE;
                default:                         state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d    = '0;
        inflight_d = '0;
        for (int i = 0; i < NSRC; i++) begin
            valid_d[i]    = (state_d[i] == ST_REQ);
            inflight_d[i] = (state_d[i] == ST_INFLIGHT);
        end
        any_valid_d = |valid_d;
    end

    // Outputs are registered copies of the next-state decode, so io_ready/io_complete never
    // reach an output combinationally yet the outputs stay aligned with state_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                state_q[i] <= ST_IDLE;
            end
            valid_q     <= '0;
            inflight_q  <= '0;
            any_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                state_q[i] <= state_d[i];
            end
            valid_q     <= valid_d;
            inflight_q  <= inflight_d;
            any_valid_q <= any_valid_d;
        end
    end

    assign io_valid     = valid_q;
    assign io_inflight  = inflight_q;
    assign io_any_valid = any_valid_q;

endmodule

// File: tb/tb_plic_gateway_sync.sv
// Scoreboard bench for plic_gateway_sync: each scenario queues the outputs it expects after
// every clock edge and compares them one cycle later.
module tb_plic_gateway_sync;

    logic       clock;
    logic       reset;
    logic [3:0] io_src;
    logic [3:0] io_valid;
    logic [3:0] io_ready;
    logic [3:0] io_complete;
    logic [3:0] io_inflight;
    logic       io_any_valid;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] inflight;
        logic       any;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    plic_gateway_sync #(.NSRC(4), .SYNC_STAGES(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_src       (io_src),
        .io_valid     (io_valid),
        .io_ready     (io_ready),
        .io_complete  (io_complete),
        .io_inflight  (io_inflight),
        .io_any_valid (io_any_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push_exp(input logic [3:0] v, input logic [3:0] f, input string tag);
        exp_t x;
        x.valid    = v;
        x.inflight = f;
        x.any      = |v;
        x.tag      = tag;
        sb.push_back(x);
    endtask

    task automatic test_reset;
        reset       = 1'b0;
        io_src      = '0;
        io_ready    = '0;
        io_complete = '0;
        #2 reset = 1'b1;
        #1;
        push_exp(4'h0, 4'h0, "reset_assert");
        e = sb.pop_front();
        n_cmp++;
        if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
            n_bad++;
            $display("FAIL %s: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                     e.tag, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            push_exp(4'h0, 4'h0, "idle_quiet");
            @(posedge clock); #1;
            e = sb.pop_front();
            n_cmp++;
            if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
                n_bad++;
                $display("FAIL %s c=%0d: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                         e.tag, c, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
            end
        end
    endtask

    // Source 0: SYNC_STAGES+1 latency, held request, accept, then completion with level low.
    task automatic test_latency;
        for (int c = 1; c <= 34; c++) begin
            io_ready    = '0;
            io_complete = '0;
            if (c == 1)  io_src[0]      = 1'b1;
            if (c == 24) io_ready[0]    = 1'b1;
            if (c == 25) io_src[0]      = 1'b0;
            if (c == 29) io_complete[0] = 1'b1;
            if (c < 4 || c >= 29) push_exp(4'h0, 4'h0, "latency");
            else if (c < 24)      push_exp(4'h1, 4'h0, "latency");
            else                  push_exp(4'h0, 4'h1, "latency");
            @(posedge clock); #1;
            e = sb.pop_front();
            n_cmp++;
            if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
                n_bad++;
                $display("FAIL %s c=%0d: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                         e.tag, c, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
            end
        end
        io_ready    = '0;
        io_complete = '0;
    endtask

    // Source 1: level drops while in REQ, stray complete/ready pulses in the wrong states.
    task automatic test_drop_in_req;
        for (int c = 1; c <= 25; c++) begin
            io_ready    = '0;
            io_complete = '0;
            if (c == 1)  io_src[1]      = 1'b1;
            if (c == 5)  io_src[1]      = 1'b0;
            if (c == 8)  io_complete[1] = 1'b1;
            if (c == 13) io_ready[1]    = 1'b1;
            if (c == 18) io_complete[1] = 1'b1;
            if (c == 21) io_ready[1]    = 1'b1;
            if (c == 23) io_complete[1] = 1'b1;
            if (c < 4 || c >= 18) push_exp(4'h0, 4'h0, "drop_in_req");
            else if (c < 13)      push_exp(4'h2, 4'h0, "drop_in_req");
            else                  push_exp(4'h0, 4'h2, "drop_in_req");
            @(posedge clock); #1;
            e = sb.pop_front();
            n_cmp++;
            if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
                n_bad++;
                $display("FAIL %s c=%0d: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                         e.tag, c, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
            end
        end
        io_ready    = '0;
        io_complete = '0;
    endtask

    // Source 2: level held across completion re-arms with exactly one idle cycle.
    task automatic test_back_to_back;
        for (int c = 1; c <= 19; c++) begin
            io_ready    = '0;
            io_complete = '0;
            if (c == 1)  io_src[2]      = 1'b1;
            if (c == 6)  io_ready[2]    = 1'b1;
            if (c == 9)  io_complete[2] = 1'b1;
            if (c == 12) begin
                io_ready[2] = 1'b1;
                io_src[2]   = 1'b0;
            end
            if (c == 16) io_complete[2] = 1'b1;
            if (c < 4 || c == 9 || c >= 16)  push_exp(4'h0, 4'h0, "back_to_back");
            else if (c < 6 || c == 10 || c == 11) push_exp(4'h4, 4'h0, "back_to_back");
            else                             push_exp(4'h0, 4'h4, "back_to_back");
            @(posedge clock); #1;
            e = sb.pop_front();
            n_cmp++;
            if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
                n_bad++;
                $display("FAIL %s c=%0d: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                         e.tag, c, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
            end
        end
        io_ready    = '0;
        io_complete = '0;
    endtask

    // Source 3: ready and complete on the same edge in REQ; ready wins.
    task automatic test_ready_complete_same;
        for (int c = 1; c <= 15; c++) begin
            io_ready    = '0;
            io_complete = '0;
            if (c == 1) io_src[3] = 1'b1;
            if (c == 5) begin
                io_ready[3]    = 1'b1;
                io_complete[3] = 1'b1;
            end
            if (c == 6)  io_src[3]      = 1'b0;
            if (c == 12) io_complete[3] = 1'b1;
            if (c < 4 || c >= 12) push_exp(4'h0, 4'h0, "ready_complete");
            else if (c == 4)      push_exp(4'h8, 4'h0, "ready_complete");
            else                  push_exp(4'h0, 4'h8, "ready_complete");
            @(posedge clock); #1;
            e = sb.pop_front();
            n_cmp++;
            if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
                n_bad++;
                $display("FAIL %s c=%0d: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                         e.tag, c, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
            end
        end
        io_ready    = '0;
        io_complete = '0;
    endtask

    // All sources in flight, then reset asserted between edges and released with levels high.
    task automatic test_reset_mid;
        for (int c = 1; c <= 7; c++) begin
            io_ready    = '0;
            io_complete = '0;
            if (c == 1) io_src   = 4'hF;
            if (c == 5) io_ready = 4'hF;
            if (c < 4)       push_exp(4'h0, 4'h0, "all_sources");
            else if (c == 4) push_exp(4'hF, 4'h0, "all_sources");
            else             push_exp(4'h0, 4'hF, "all_sources");
            @(posedge clock); #1;
            e = sb.pop_front();
            n_cmp++;
            if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
                n_bad++;
                $display("FAIL %s c=%0d: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                         e.tag, c, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
            end
        end
        io_ready = '0;
        #2 reset = 1'b1;
        #1;
        push_exp(4'h0, 4'h0, "async_reset");
        e = sb.pop_front();
        n_cmp++;
        if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
            n_bad++;
            $display("FAIL %s: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                     e.tag, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c < 4) push_exp(4'h0, 4'h0, "post_reset");
            else       push_exp(4'hF, 4'h0, "post_reset");
            @(posedge clock); #1;
            e = sb.pop_front();
            n_cmp++;
            if (io_valid !== e.valid || io_inflight !== e.inflight || io_any_valid !== e.any) begin
                n_bad++;
                $display("FAIL %s c=%0d: got valid=%h inflight=%h any=%b, expected valid=%h inflight=%h any=%b",
                         e.tag, c, io_valid, io_inflight, io_any_valid, e.valid, e.inflight, e.any);
            end
        end
        io_src = '0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_drop_in_req();
        test_back_to_back();
        test_ready_complete_same();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
